// File: rtl/xy_vector_player_if.sv
// Point-RAM write port, playback controls and DAC-side outputs of xy_vector_player.
// The host side drives through master; the player attaches as slave.
interface xy_vector_player_if #(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int AW      = 5,
  parameter int DWELL_W = 8
);
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [XW-1:0]      wr_x;
  logic [YW-1:0]      wr_y;
  logic               wr_blank;
  logic               start;
  logic               stop;
  logic               loop_mode;
  logic [AW-1:0]      last_idx;
  logic [DWELL_W-1:0] dwell;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic               blank;
  logic               trig;
  logic               busy;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_x, wr_y, wr_blank, start, stop, loop_mode, last_idx, dwell,
    input  x, y, blank, trig, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_y, wr_blank, start, stop, loop_mode, last_idx, dwell,
    output x, y, blank, trig, busy, done
  );
endinterface

// File: rtl/xy_vector_player.sv
// Replays a host-loaded XY point list to the scope DAC pins with per-point dwell, blanking
// and a frame trigger; first point shows two edges after start, then gapless via prefetch.
module xy_vector_player #(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int DEPTH   = 32,
  parameter int DWELL_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  xy_vector_player_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = 1 + XW + YW;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ram_q [DEPTH];
  logic [PW-1:0]      pf_dat_q;
  logic               advance;
  logic [AW-1:0]      rd_idx_q, rd_idx_d;
  logic [AW-1:0]      last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               loop_q, loop_d;
  logic               shown_q, shown_d;
  logic               pf_trig_q, pf_trig_d;
  logic               pf_last_q, pf_last_d;
  logic               cur_last_q, cur_last_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               blank_q, blank_d;
  logic               trig_q, trig_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // pf_dat_q always holds the point that will be shown next, so a hold expiry can load it at once.
  always_ff @(posedge clk) begin
    if (bus.wr_en) ram_q[bus.wr_addr] <= {bus.wr_blank, bus.wr_x, bus.wr_y};
    if (advance) pf_dat_q <= ram_q[rd_idx_q];
  end

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    last_d     = last_q;
    dwell_d    = dwell_q;
    loop_d     = loop_q;
    cnt_d      = cnt_q;
    shown_d    = shown_q;
    pf_trig_d  = pf_trig_q;
    pf_last_d  = pf_last_q;
    cur_last_d = cur_last_q;
    x_d        = x_q;
    y_d        = y_q;
    blank_d    = blank_q;
    trig_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    advance    = 1'b0;

    if (bus.stop && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      blank_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start && !bus.stop) begin
            state_d  = FETCH;
            loop_d   = bus.loop_mode;
            last_d   = bus.last_idx;
            dwell_d  = bus.dwell;
            rd_idx_d = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
          end
        end
        FETCH: begin
          advance = 1'b1;
          state_d = PLAY;
          shown_d = 1'b0;
          cnt_d   = '0;
        end
        PLAY: begin
          if (shown_q && cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (shown_q && cur_last_q && !loop_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // shown_q is clear only on the first load of a start, which has no previous point to retire.
            advance    = 1'b1;
            shown_d    = 1'b1;
            cnt_d      = dwell_q;
            cur_last_d = pf_last_q;
            trig_d     = pf_trig_q;
            {blank_d, x_d, y_d} = pf_dat_q;
          end
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        pf_trig_d = (rd_idx_q == '0);
        pf_last_d = (rd_idx_q == last_q);
        rd_idx_d  = (rd_idx_q == last_q) ? '0 : rd_idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_idx_q   <= '0;
      last_q     <= '0;
      dwell_q    <= '0;
      loop_q     <= 1'b0;
      cnt_q      <= '0;
      shown_q    <= 1'b0;
      pf_trig_q  <= 1'b0;
      pf_last_q  <= 1'b0;
      cur_last_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      blank_q    <= 1'b1;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      last_q     <= last_d;
      dwell_q    <= dwell_d;
      loop_q     <= loop_d;
      cnt_q      <= cnt_d;
      shown_q    <= shown_d;
      pf_trig_q  <= pf_trig_d;
      pf_last_q  <= pf_last_d;
      cur_last_q <= cur_last_d;
      x_q        <= x_d;
      y_q        <= y_d;
      blank_q    <= blank_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.blank = blank_q;
  assign bus.trig  = trig_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_xy_vector_player.sv
// Bench for xy_vector_player: per-cycle expected outputs are queued from a point-list model
// and popped against the DUT one cycle at a time.
module tb_xy_vector_player;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xy_vector_player_if #(.XW(8), .YW(7), .AW(5), .DWELL_W(8)) bus ();

  xy_vector_player #(.XW(8), .YW(7), .DEPTH(32), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       blank;
    logic       trig;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mx[4];
  logic [6:0] my[4];
  logic       mb[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.x = bus.x; o.y = bus.y; o.blank = bus.blank;
    o.trig = bus.trig; o.busy = bus.busy; o.done = bus.done;
    return o;
  endfunction

  function automatic obs_t mk(input logic [7:0] x, input logic [6:0] y, input logic b,
                              input logic t, input logic bz, input logic d);
    obs_t o;
    o.x = x; o.y = y; o.blank = b; o.trig = t; o.busy = bz; o.done = d;
    return o;
  endfunction

  task automatic push_pass(input int last, input int dwell);
    for (int k = 0; k <= last; k++)
      for (int d = 0; d <= dwell; d++)
        sb.push_back(mk(mx[k], my[k], mb[k], (k == 0 && d == 0), 1'b1, 1'b0));
  endtask

  task automatic wr_point(input int a, input logic [7:0] x, input logic [6:0] y, input logic b);
    bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_x = x; bus.wr_y = y; bus.wr_blank = b;
    step();
    bus.wr_en = 1'b0;
    mx[a] = x; my[a] = y; mb[a] = b;
  endtask

  task automatic start_play(input logic lp, input int last, input int dwell);
    bus.loop_mode = lp; bus.last_idx = 5'(last); bus.dwell = 8'(dwell); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    obs_t got, exp;
    rst_n = 1'b0;
    repeat (3) step();
    got = observe(); exp = mk(8'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset got %h required %h", got, exp);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_oneshot();
    obs_t got, exp;
    int n = 0;
    wr_point(0, 8'd10, 7'd5, 1'b0);
    wr_point(1, 8'd200, 7'd100, 1'b0);
    wr_point(2, 8'd50, 7'd60, 1'b1);
    wr_point(3, 8'd255, 7'd127, 1'b0);
    start_play(1'b0, 3, 0);
    got = observe(); exp = mk(8'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL oneshot_fetch got %h required %h", got, exp);
    end
    push_pass(3, 0);
    sb.push_back(mk(8'd255, 7'd127, 1'b0, 1'b0, 1'b0, 1'b1));
    sb.push_back(mk(8'd255, 7'd127, 1'b0, 1'b0, 1'b0, 1'b1));
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front(); got = observe(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL oneshot[%0d] got x=%0d y=%0d b=%b t=%b busy=%b done=%b required x=%0d y=%0d b=%b t=%b busy=%b done=%b",
                 n, got.x, got.y, got.blank, got.trig, got.busy, got.done,
                 exp.x, exp.y, exp.blank, exp.trig, exp.busy, exp.done);
      end
      n++;
    end
  endtask

  task automatic test_loop_dwell();
    obs_t got, exp;
    int n = 0;
    start_play(1'b1, 3, 2);
    got = observe(); checks++;
    if (got.done !== 1'b0 || got.busy !== 1'b1) begin
      errors++;
      $display("FAIL loop_restart got busy=%b done=%b required busy=1 done=0", got.busy, got.done);
    end
    push_pass(3, 2);
    push_pass(3, 2);
    sb.push_back(mk(mx[0], my[0], mb[0], 1'b1, 1'b1, 1'b0));
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front(); got = observe(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL loop[%0d] got x=%0d y=%0d b=%b t=%b busy=%b done=%b required x=%0d y=%0d b=%b t=%b busy=%b done=%b",
                 n, got.x, got.y, got.blank, got.trig, got.busy, got.done,
                 exp.x, exp.y, exp.blank, exp.trig, exp.busy, exp.done);
      end
      if (n == 5) bus.start = 1'b1;
      if (n == 6) bus.start = 1'b0;
      n++;
    end
  endtask

  task automatic test_stop();
    obs_t got, exp;
    bus.stop = 1'b1; bus.start = 1'b1;
    step();
    bus.stop = 1'b0; bus.start = 1'b0;
    exp = mk(8'd10, 7'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      got = observe(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stop[%0d] got %h required %h", i, got, exp);
      end
      step();
    end
  endtask

  task automatic test_rewrite();
    obs_t got, exp;
    int n = 0;
    start_play(1'b1, 3, 1);
    push_pass(3, 1);
    mx[1] = 8'd77; my[1] = 7'd33; mb[1] = 1'b0;
    push_pass(3, 1);
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front(); got = observe(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rewrite[%0d] got x=%0d y=%0d b=%b t=%b busy=%b done=%b required x=%0d y=%0d b=%b t=%b busy=%b done=%b",
                 n, got.x, got.y, got.blank, got.trig, got.busy, got.done,
                 exp.x, exp.y, exp.blank, exp.trig, exp.busy, exp.done);
      end
      if (n == 4) begin
        bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_x = 8'd77; bus.wr_y = 7'd33; bus.wr_blank = 1'b0;
        bus.dwell = 8'd0;
      end
      if (n == 5) bus.wr_en = 1'b0;
      n++;
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    got = observe(); exp = mk(8'd255, 7'd127, 1'b1, 1'b0, 1'b0, 1'b0); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rewrite_stop got %h required %h", got, exp);
    end
  endtask

  task automatic test_single_reset();
    obs_t got, exp;
    int n = 0;
    start_play(1'b1, 0, 0);
    for (int i = 0; i < 6; i++) sb.push_back(mk(mx[0], my[0], mb[0], 1'b1, 1'b1, 1'b0));
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front(); got = observe(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single[%0d] got x=%0d t=%b busy=%b required x=%0d t=%b busy=%b",
                 n, got.x, got.trig, got.busy, exp.x, exp.trig, exp.busy);
      end
      n++;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp = mk(8'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      got = observe(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midrun_reset[%0d] got %h required %h", i, got, exp);
      end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_blank = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_mode = 1'b0; bus.last_idx = '0; bus.dwell = '0;
    test_reset();
    test_oneshot();
    test_loop_dwell();
    test_stop();
    test_rewrite();
    test_single_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
